// File: rtl/dht11_responder_if.sv
// dht11_responder_if: signal bundle between a DHT11 responder and whatever drives/observes it.
// Latency: none (pure wiring).
// Backpressure: none; the single-wire protocol is purely timed.
// Ports: master = host/bench side (drives EN, DHT_IN, data bytes), slave = responder side.
// Optional: DHT11_RESP_CRC_FAULT_EN adds CRC_FAULT (master -> slave).
interface dht11_responder_if;
  logic       EN;
  logic       DHT_IN;
  logic       DHT_OE;
  logic [7:0] HUM_INT;
  logic [7:0] HUM_FLOAT;
  logic [7:0] TEMP_INT;
  logic [7:0] TEMP_FLOAT;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;
`ifdef DHT11_RESP_CRC_FAULT_EN
  logic       CRC_FAULT;

  modport master (
    output EN, DHT_IN, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC_FAULT,
    input  DHT_OE, BUSY, DONE, ERROR
  );

  modport slave (
    input  EN, DHT_IN, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC_FAULT,
    output DHT_OE, BUSY, DONE, ERROR
  );
`else
  modport master (
    output EN, DHT_IN, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT,
    input  DHT_OE, BUSY, DONE, ERROR
  );

  modport slave (
    input  EN, DHT_IN, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT,
    output DHT_OE, BUSY, DONE, ERROR
  );
`endif
endinterface

// File: rtl/dht11_responder.sv
// dht11_responder: cycle-accurate DHT11 sensor emulator (responder end of the single-wire bus).
// Latency: start accepted 3 cycles after the host releases the line (2-flop sync + state reg);
//          every protocol phase then lasts exactly N us of CYCLES_PER_US cycles.
// Backpressure: none; a host fighting the released line aborts the frame with an ERROR pulse.
// Ports: CLK; RST_N (synchronous, active low); bus (slave modport of dht11_responder_if):
//   in : EN, DHT_IN (async pad level), HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT
//   out: DHT_OE (1 = pull low), BUSY, DONE (1-cycle), ERROR (1-cycle)
// Optional: `define DHT11_RESP_CRC_FAULT_EN adds input CRC_FAULT; latched high, the CRC is inverted.
module dht11_responder #(
  parameter int CYCLES_PER_US = 100,
  parameter int MIN_START_US  = 18000,
  parameter int CONTENTION_US = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  dht11_responder_if.slave bus
);

  localparam int RESP_WAIT_US = 30;
  localparam int RESP_LOW_US  = 80;
  localparam int RESP_HIGH_US = 80;
  localparam int BIT_LOW_US   = 50;
  localparam int BIT0_HIGH_US = 26;
  localparam int BIT1_HIGH_US = 70;
  localparam int END_LOW_US   = 50;

  // The us counter must hold both the start-pulse threshold and the longest fixed phase.
  localparam int US_MAX   = (MIN_START_US > RESP_LOW_US) ? MIN_START_US : RESP_LOW_US;
  localparam int US_W     = $clog2(US_MAX + 1);
  localparam int PRE_W    = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam int CONT_CYC = CONTENTION_US * CYCLES_PER_US;
  localparam int CONT_W   = $clog2(CONT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_DET,
    S_RESP_WAIT,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [US_W-1:0]   us_q, us_d;
  logic [CONT_W-1:0] cont_q, cont_d;
  logic [5:0]        bit_idx_q, bit_idx_d;
  logic [39:0]       frame_q, frame_d;
  logic              armed_q, armed_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              line;
  logic              tick;
  logic              cur_bit;
  logic              in_high;
  logic              contention;
  logic [US_W-1:0]   us_cap;
  logic [7:0]        crc_sum;
  logic [7:0]        crc_tx;

  // True on the last cycle of an n-us phase.
  function automatic logic phase_end(input logic t, input logic [US_W-1:0] us, input int n);
    return t && (us == US_W'(n - 1));
  endfunction

  assign line    = sync2_q;
  assign tick    = (pre_q == PRE_W'(CYCLES_PER_US - 1));
  assign cur_bit = frame_q[bit_idx_q];
  assign in_high = (state_q == S_RESP_HIGH) || (state_q == S_BIT_HIGH);

  // cont_q counts consecutive low cycles already seen; this cycle completes the run.
  assign contention = in_high && !line && (cont_q == CONT_W'(CONT_CYC - 1));

  // 8-bit sum wraps naturally, giving the mod-256 checksum.
  assign crc_sum = bus.HUM_INT + bus.HUM_FLOAT + bus.TEMP_INT + bus.TEMP_FLOAT;
`ifdef DHT11_RESP_CRC_FAULT_EN
  assign crc_tx  = bus.CRC_FAULT ? ~crc_sum : crc_sum;
`else
  assign crc_tx  = crc_sum;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    armed_d   = armed_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // A start needs a high->low edge seen from IDLE; a line stuck low after an
        // abort or a finished frame never arms.
        if (line) begin
          armed_d = 1'b1;
        end else if (bus.EN && armed_q) begin
          state_d = S_START_DET;
        end
      end

      S_START_DET: begin
        if (line) begin
          armed_d = 1'b0;
          if (us_q >= US_W'(MIN_START_US)) begin
            frame_d   = {bus.HUM_INT, bus.HUM_FLOAT, bus.TEMP_INT, bus.TEMP_FLOAT, crc_tx};
            bit_idx_d = 6'd39;
            busy_d    = 1'b1;
            state_d   = S_RESP_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_RESP_WAIT: begin
        if (phase_end(tick, us_q, RESP_WAIT_US)) state_d = S_RESP_LOW;
      end

      S_RESP_LOW: begin
        if (phase_end(tick, us_q, RESP_LOW_US)) state_d = S_RESP_HIGH;
      end

      S_RESP_HIGH: begin
        if (contention) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          armed_d = 1'b0;
          state_d = S_IDLE;
        end else if (phase_end(tick, us_q, RESP_HIGH_US)) begin
          state_d = S_BIT_LOW;
        end
      end

      S_BIT_LOW: begin
        if (phase_end(tick, us_q, BIT_LOW_US)) state_d = S_BIT_HIGH;
      end

      S_BIT_HIGH: begin
        if (contention) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          armed_d = 1'b0;
          state_d = S_IDLE;
        end else if (phase_end(tick, us_q, cur_bit ? BIT1_HIGH_US : BIT0_HIGH_US)) begin
          if (bit_idx_q == 6'd0) begin
            state_d = S_END_LOW;
          end else begin
            bit_idx_d = bit_idx_q - 6'd1;
            state_d   = S_BIT_LOW;
          end
        end
      end

      S_END_LOW: begin
        if (phase_end(tick, us_q, END_LOW_US)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          armed_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Prescaler, us counter and contention counter all restart on any state change,
  // so each phase begins on a fresh microsecond boundary.
  always_comb begin
    us_cap = (state_q == S_START_DET) ? US_W'(MIN_START_US) : US_W'(US_MAX);
    pre_d  = '0;
    us_d   = '0;
    cont_d = '0;
    if (state_d == state_q) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      us_d  = (tick && (us_q != us_cap)) ? us_q + 1'b1 : us_q;
      if (in_high && !line) begin
        cont_d = (cont_q != CONT_W'(CONT_CYC)) ? cont_q + 1'b1 : cont_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pre_q     <= '0;
      us_q      <= '0;
      cont_q    <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= bus.DHT_IN;
      sync2_q   <= sync1_q;
      pre_q     <= pre_d;
      us_q      <= us_d;
      cont_q    <= cont_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      armed_q   <= armed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Line is driven low only in the three low phases; decoding state_q directly
  // means reset releases the line on the very edge that samples RST_N.
  assign bus.DHT_OE = (state_q == S_RESP_LOW) || (state_q == S_BIT_LOW) || (state_q == S_END_LOW);
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.ERROR  = err_q;

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: randomized and directed stimulus against a waveform model of the DHT11 frame.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_dht11_responder;
  localparam int CPU    = 2;
  localparam int MIN_US = 100;
  localparam int CONT_US = 4;

  typedef struct packed {
    logic oe;
    logic busy;
    logic done;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N;
  logic host_low;

  int n_tests = 0;
  int n_fail  = 0;

  dht11_responder_if bus();

  // Open-drain wire: low if either side pulls.
  assign bus.DHT_IN = ~(host_low | bus.DHT_OE);

  dht11_responder #(
    .CYCLES_PER_US(CPU),
    .MIN_START_US (MIN_US),
    .CONTENTION_US(CONT_US)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Monitor state
  int   done_cnt = 0;
  int   err_cnt  = 0;
  bit   busy_seen = 1'b0;
  bit   oe_seen   = 1'b0;
  bit   dec_on    = 1'b0;
  int   nrise     = 0;
  int   run_len   = 0;
  int   runs [0:40];
  logic prev_oe   = 1'b0;
  exp_t exp_q [$];
  bit   started   = 1'b0;
  int   stream_pos = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Model: the five transmitted bytes.
  function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d,
                                              input bit fault);
    logic [7:0] crc;
    crc = 8'((int'(a) + int'(b) + int'(c) + int'(d)) % 256);
    if (fault) crc = ~crc;
    return {a, b, c, d, crc};
  endfunction

  task automatic push(input logic oe, input logic busy, input logic done, input int n);
    exp_t e;
    e.oe = oe; e.busy = busy; e.done = done;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Expected per-cycle waveform from the first response low to one cycle after DONE.
  task automatic arm_stream(input logic [39:0] f);
    exp_q.delete();
    started = 1'b0;
    stream_pos = 0;
    push(1'b1, 1'b1, 1'b0, 80 * CPU);
    push(1'b0, 1'b1, 1'b0, 80 * CPU);
    for (int k = 39; k >= 0; k--) begin
      push(1'b1, 1'b1, 1'b0, 50 * CPU);
      push(1'b0, 1'b1, 1'b0, (f[k] ? 70 : 26) * CPU);
    end
    push(1'b1, 1'b1, 1'b0, 50 * CPU);
    push(1'b0, 1'b0, 1'b1, 1);
    push(1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic arm_decoder();
    nrise = 0;
    run_len = 0;
    for (int i = 0; i <= 40; i++) runs[i] = 0;
    dec_on = 1'b1;
  endtask

  function automatic logic [39:0] decode();
    logic [39:0] v;
    v = '0;
    for (int j = 1; j <= 40; j++) v[40 - j] = (runs[j] > 48 * CPU);
    return v;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (bus.DONE === 1'b1) done_cnt++;
    if (bus.ERROR === 1'b1) err_cnt++;
    if (bus.BUSY === 1'b1) busy_seen = 1'b1;
    if (bus.DHT_OE === 1'b1) oe_seen = 1'b1;
    if (bus.DONE === 1'b1 || bus.ERROR === 1'b1) begin
      n_tests++;
      if (bus.DONE === 1'b1 && bus.ERROR === 1'b1) begin
        n_fail++;
        $display("FAIL done_error_exclusive: DONE=%b ERROR=%b, want not both", bus.DONE, bus.ERROR);
      end
    end
    if (dec_on) begin
      if (bus.DHT_OE === 1'b1 && prev_oe !== 1'b1) begin
        if (nrise >= 1 && nrise <= 41) runs[nrise - 1] = run_len;
        nrise++;
        run_len = 0;
      end else if (bus.DHT_OE === 1'b0 && nrise > 0) begin
        run_len++;
      end
    end
    if (exp_q.size() != 0 && (started || bus.DHT_OE === 1'b1)) begin
      started = 1'b1;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.DHT_OE, bus.BUSY, bus.DONE, bus.ERROR} !== {e.oe, e.busy, e.done, 1'b0}) begin
        n_fail++;
        $display("FAIL frame_wave step %0d: oe/busy/done/err=%b, want %b", stream_pos,
                 {bus.DHT_OE, bus.BUSY, bus.DONE, bus.ERROR}, {e.oe, e.busy, e.done, 1'b0});
        exp_q.delete();
      end
      stream_pos++;
    end
    if (exp_q.size() == 0) started = 1'b0;
    prev_oe = bus.DHT_OE;
  end

  task automatic host_start(input int us);
    @(posedge CLK); #1 host_low = 1'b1;
    repeat (us * CPU) @(posedge CLK);
    #1 host_low = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic run_frame(input string tag, input int low_us, input bit mutate,
                           output logic [39:0] dec);
    logic [39:0] f;
    int lat;
    int base_done;
    bit fault;
    fault = 1'b0;
`ifdef DHT11_RESP_CRC_FAULT_EN
    fault = bus.CRC_FAULT;
`endif
    f = model_frame(bus.HUM_INT, bus.HUM_FLOAT, bus.TEMP_INT, bus.TEMP_FLOAT, fault);
    arm_stream(f);
    arm_decoder();
    base_done = done_cnt;
    host_start(low_us);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      if (bus.DHT_OE === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_tests++;
    if (lat < 60 || lat > 66) begin
      n_fail++;
      $display("FAIL %s resp_wait: %0d cycles release-to-low, want 60..66", tag, lat);
    end
    if (mutate) begin
      bus.HUM_INT    = 8'($urandom);
      bus.HUM_FLOAT  = 8'($urandom);
      bus.TEMP_INT   = 8'($urandom);
      bus.TEMP_FLOAT = 8'($urandom);
      bus.EN         = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(negedge CLK);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s frame_timeout: %0d waveform steps left, want 0", tag, exp_q.size());
      exp_q.delete();
    end
    idle(2);
    dec_on = 1'b0;
    dec = decode();
    check({tag, " resp_high_len"}, 64'(runs[0]), 64'(80 * CPU));
    check({tag, " decoded"}, 64'(dec), 64'(f));
    check({tag, " done_count"}, 64'(done_cnt - base_done), 64'd1);
    check({tag, " busy_after"}, 64'(bus.BUSY), 64'd0);
    bus.EN = 1'b1;
  endtask

  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    bus.HUM_INT = a; bus.HUM_FLOAT = b; bus.TEMP_INT = c; bus.TEMP_FLOAT = d;
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] dec;
    logic [39:0] f;
    int lat;
    int base_err;
    int base_done;
    int bad1;
    int bad0;
    bit got;
    bit found;

    RST_N = 1'b0;
    host_low = 1'b0;
    bus.EN = 1'b1;
    set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
`ifdef DHT11_RESP_CRC_FAULT_EN
    bus.CRC_FAULT = 1'b0;
`endif
    idle(3);
    check("reset_oe", 64'(bus.DHT_OE), 64'd0);
    check("reset_busy", 64'(bus.BUSY), 64'd0);
    check("reset_done", 64'(bus.DONE), 64'd0);
    check("reset_error", 64'(bus.ERROR), 64'd0);
    @(posedge CLK); #1 RST_N = 1'b1;
    idle(10);

    // Basic frame
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
    f = model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
    check("model_crc_basic", 64'(f[7:0]), 64'h55);
    run_frame("basic", 120, 1'b0, dec);
    check("basic_literal", 64'(dec), 64'h37_00_19_05_55);
    idle(20);

    // Short start
    oe_seen = 1'b0; busy_seen = 1'b0; base_err = err_cnt;
    host_start(60);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (bus.ERROR === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_tests++;
    if (lat < 2 || lat > 6) begin
      n_fail++;
      $display("FAIL short_start_error: latency %0d cycles, want 2..6", lat);
    end
    idle(20);
    check("short_err_count", 64'(err_cnt - base_err), 64'd1);
    check("short_oe_never", 64'(oe_seen), 64'd0);
    check("short_busy_never", 64'(busy_seen), 64'd0);

    // All 0xFF: checksum wraps
    set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    f = model_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    check("model_crc_ff", 64'(f[7:0]), 64'hFC);
    run_frame("all_ff", 130, 1'b0, dec);
    check("all_ff_literal", 64'(dec), 64'hFF_FF_FF_FF_FC);
    bad1 = 0; bad0 = 0;
    for (int j = 1; j <= 40; j++) begin
      if (dec[40 - j] && runs[j] != 70 * CPU) bad1++;
      if (!dec[40 - j] && runs[j] != 26 * CPU) bad0++;
    end
    check("all_ff_bit1_len_bad", 64'(bad1), 64'd0);
    check("all_ff_bit0_len_bad", 64'(bad0), 64'd0);
    idle(20);

    // Contention during BIT_HIGH of bit 20
    set_bytes(8'hA5, 8'h3C, 8'h5A, 8'hC3);
    arm_decoder();
    base_done = done_cnt; base_err = err_cnt;
    host_start(120);
    found = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge CLK);
      if (nrise == 21 && bus.DHT_OE === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("contention_reach_bit20", 64'(found), 64'd1);
    repeat (4) @(posedge CLK);
    #1 host_low = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.ERROR === 1'b1 && !got) begin
        got = 1'b1;
        check("contention_oe", 64'(bus.DHT_OE), 64'd0);
        check("contention_busy", 64'(bus.BUSY), 64'd0);
      end
    end
    @(posedge CLK); #1 host_low = 1'b0;
    dec_on = 1'b0;
    check("contention_error_seen", 64'(got), 64'd1);
    idle(200);
    check("contention_no_done", 64'(done_cnt - base_done), 64'd0);
    check("contention_err_once", 64'(err_cnt - base_err), 64'd1);
    run_frame("after_abort", 110, 1'b0, dec);
    idle(20);

    // Reset during RESP_LOW
    host_start(120);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (bus.DHT_OE === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reach_resp_low", 64'(found), 64'd1);
    @(posedge CLK); #1 RST_N = 1'b0;
    @(posedge CLK); #1;
    check("rst_mid_oe", 64'(bus.DHT_OE), 64'd0);
    check("rst_mid_busy", 64'(bus.BUSY), 64'd0);
    RST_N = 1'b1;
    idle(20);

    // EN=0 ignores a long start
    bus.EN = 1'b0;
    oe_seen = 1'b0; busy_seen = 1'b0; base_err = err_cnt;
    host_start(200);
    idle(100);
    check("en0_oe_never", 64'(oe_seen), 64'd0);
    check("en0_busy_never", 64'(busy_seen), 64'd0);
    check("en0_no_error", 64'(err_cnt - base_err), 64'd0);
    bus.EN = 1'b1;
    idle(20);

`ifdef DHT11_RESP_CRC_FAULT_EN
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
    bus.CRC_FAULT = 1'b1;
    run_frame("crc_fault", 120, 1'b0, dec);
    check("crc_fault_byte", 64'(dec[7:0]), 64'hAA);
    bus.CRC_FAULT = 1'b0;
    idle(20);
`endif

    // Random frames; bytes and EN change after acceptance
    for (int n = 0; n < 3; n++) begin
      set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run_frame("random", 105 + int'($urandom_range(0, 40)), 1'b1, dec);
      idle(10 + int'($urandom_range(0, 30)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
